// File: rtl/cic_conv_ctrl.sv
// rtl/cic_conv_ctrl.sv - conversion sequencer and sample buffer for a CIC decimator
//
// Sequences one conversion: the CIC is held in reset (FLUSH), the first
// decimated samples are discarded while the filter settles (SETTLE), then the
// samples are buffered for a valid/ready consumer (RUN). Single-shot runs stop
// after num_samples strobes and pulse done. Continuous runs keep going until stop.
//
// Build option: define CIC_CTRL_FIFO_EN to use a 4-entry FIFO as the sample
// buffer. Without it, the buffer is a single holding register.
//
// Parameters:
//   NUMBITS        - sample width; matches the CIC output width
//   SETTLE_SAMPLES - decimated samples discarded after the flush
//   FLUSH_CYCLES   - clk cycles the CIC is held in reset at conversion start
//
// Ports:
//   clk          in   modulator clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse that begins a conversion (accepted in IDLE only)
//   stop         in   pulse that aborts or ends a conversion
//   continuous   in   1 = free-running, 0 = single-shot; sampled on start
//   num_samples  in   single-shot sample count; 0 means 256; sampled on start
//   cic_strobe   in   pulse when cic_out updates
//   cic_out      in   CIC decimated output
//   cic_rst_n    out  registered soft reset to the CIC, active low
//   sample_data  out  head of the sample buffer
//   sample_valid out  sample_data is valid
//   sample_ready in   consumer accepts sample_data
//   busy         out  registered, high whenever the FSM is not in IDLE
//   done         out  one-cycle pulse on single-shot completion
//   overflow     out  sticky, set when a sample is dropped; cleared by start

module cic_conv_ctrl #(
    parameter int NUMBITS        = 25,
    parameter int SETTLE_SAMPLES = 3,
    parameter int FLUSH_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [7:0]         num_samples,
    input  logic               cic_strobe,
    input  logic [NUMBITS-1:0] cic_out,
    output logic               cic_rst_n,
    output logic [NUMBITS-1:0] sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          done_n;
    logic          start_ok;

    logic [FW-1:0] flush_cnt;
    logic [8:0]    settle_cnt;
    logic [8:0]    run_cnt;
    logic [8:0]    target;
    logic          cont_q;
    logic          run_last;

    logic          wr;
    logic          rd;
    logic          wr_acc;
    logic          drop;

    // start together with stop is ignored: stop wins
    assign start_ok = (state == IDLE) && start && !stop;
    assign run_last = ((run_cnt + 9'd1) == target);
    assign wr       = (state == RUN) && cic_strobe;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                    state_n = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cic_strobe && (settle_cnt == 9'(SETTLE_SAMPLES - 1))) begin
                    // the last discarded strobe itself moves us into RUN
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cic_strobe && !cont_q && run_last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            settle_cnt <= '0;
            run_cnt    <= '0;
            target     <= '0;
            cont_q     <= 1'b0;
            cic_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            done  <= done_n;
            // registered from the next state so both outputs line up with state
            busy      <= (state_n != IDLE);
            cic_rst_n <= (state_n == SETTLE) || (state_n == RUN);

            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;

            if (state != SETTLE) begin
                settle_cnt <= '0;
            end else if (cic_strobe) begin
                settle_cnt <= settle_cnt + 9'd1;
            end

            if (state == IDLE) begin
                run_cnt <= '0;
            end else if (wr) begin
                // dropped samples count too
                run_cnt <= run_cnt + 9'd1;
            end

            if (start_ok) begin
                cont_q <= continuous;
                target <= (num_samples == 8'd0) ? 9'd256 : {1'b0, num_samples};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (start_ok) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
`ifdef CIC_CTRL_FIFO_EN
    logic [NUMBITS-1:0] mem [4];
    logic [1:0]         wr_ptr;
    logic [1:0]         rd_ptr;
    logic [2:0]         count;
    logic               full;

    assign full         = (count == 3'd4);
    assign sample_valid = (count != 3'd0);
    assign sample_data  = mem[rd_ptr];
    assign rd           = sample_valid && sample_ready;
    // a read in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_acc       = wr && (!full || rd);
    assign drop         = wr && full && !rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= cic_out;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({wr_acc, rd})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic full;

    assign full   = sample_valid;
    assign rd     = sample_valid && sample_ready;
    assign wr_acc = wr && (!full || rd);
    assign drop   = wr && full && !rd;

    // no bypass: a write into an empty register shows up the following cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (wr_acc) begin
            sample_data  <= cic_out;
            sample_valid <= 1'b1;
        end else if (rd) begin
            sample_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cic_conv_ctrl.sv
// tb/tb_cic_conv_ctrl.sv - directed self-checking bench for cic_conv_ctrl

module tb_cic_conv_ctrl;

    localparam int NB = 25;
`ifdef CIC_CTRL_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          continuous;
    logic [7:0]    num_samples;
    logic          cic_strobe;
    logic [NB-1:0] cic_out;
    logic          cic_rst_n;
    logic [NB-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          busy;
    logic          done;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    cic_conv_ctrl #(
        .NUMBITS       (NB),
        .SETTLE_SAMPLES(3),
        .FLUSH_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .num_samples (num_samples),
        .cic_strobe  (cic_strobe),
        .cic_out     (cic_out),
        .cic_rst_n   (cic_rst_n),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int gap, input logic [NB-1:0] val);
        repeat (gap) step();
        cic_strobe = 1'b1;
        cic_out    = val;
        step();
        cic_strobe = 1'b0;
    endtask

    task automatic do_start(input logic cont, input logic [7:0] n);
        continuous  = cont;
        num_samples = n;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    initial begin
        logic early_done;
        reset_n      = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        continuous   = 1'b0;
        num_samples  = 8'd0;
        cic_strobe   = 1'b0;
        cic_out      = '0;
        sample_ready = 1'b0;
        step();
        step();

        // reset state
        chk("rst_cic_rst_n", cic_rst_n, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        step();

        // single-shot, 2 samples, strobes every 256 clk
        sample_ready = 1'b1;
        do_start(1'b0, 8'd2);
        chk("a_busy_start", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_flush_%0d", i), cic_rst_n, 0);
            step();
        end
        chk("a_settle_cic_rst_n", cic_rst_n, 1);
        chk("a_settle_busy", busy, 1);
        for (int i = 0; i < 3; i++) strobe(255, 25'h0000F0 + NB'(i));
        chk("a_discard_valid", sample_valid, 0);
        strobe(255, 25'h11);
        chk("a_s1_valid", sample_valid, 1);
        chk("a_s1_data", sample_data, 32'h11);
        chk("a_s1_done", done, 0);
        strobe(255, 25'h22);
        chk("a_s2_done", done, 1);
        chk("a_s2_busy", busy, 0);
        chk("a_s2_cic_rst_n", cic_rst_n, 0);
        chk("a_s2_data", sample_data, 32'h22);
        step();
        chk("a_done_one_cycle", done, 0);
        chk("a_drained", sample_valid, 0);

        // continuous, consumer stalled, 6 strobes in RUN
        sample_ready = 1'b0;
        do_start(1'b1, 8'd1);
        repeat (4) step();
        for (int i = 0; i < 3; i++) strobe(2, 25'h0);
        for (int i = 0; i < 6; i++) begin
            strobe(1, 25'hA1 + NB'(i));
            if (i == DEPTH - 1) chk("b_no_overflow_yet", overflow, 0);
        end
        chk("b_overflow", overflow, 1);
        chk("b_valid", sample_valid, 1);
        chk("b_head_stable", sample_data, 32'hA1);
        chk("b_busy_run", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("b_stop_busy", busy, 0);
        chk("b_stop_cic_rst_n", cic_rst_n, 0);
        chk("b_stop_retain", sample_valid, 1);
        chk("b_stop_overflow_sticky", overflow, 1);
        chk("b_stop_no_done", done, 0);
        sample_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("b_drain_valid_%0d", k), sample_valid, 1);
            chk($sformatf("b_drain_data_%0d", k), sample_data, 32'hA1 + k);
            step();
        end
        chk("b_drain_empty", sample_valid, 0);

        // reset in RUN with two samples buffered
        sample_ready = 1'b0;
        do_start(1'b1, 8'd0);
        chk("c_start_clears_overflow", overflow, 0);
        repeat (4) step();
        for (int i = 0; i < 3; i++) strobe(2, 25'h0);
        strobe(1, 25'hB1);
        strobe(1, 25'hB2);
        chk("c_buffered", sample_valid, 1);
        chk("c_overflow_nonfifo", overflow, (DEPTH == 1) ? 1 : 0);
        reset_n = 1'b0;
        #1;
        chk("c_async_valid", sample_valid, 0);
        chk("c_async_busy", busy, 0);
        chk("c_async_overflow", overflow, 0);
        chk("c_async_cic_rst_n", cic_rst_n, 0);
        chk("c_async_data", sample_data, 0);
        step();
        reset_n = 1'b1;
        step();

        // stop during SETTLE after one strobe
        sample_ready = 1'b1;
        do_start(1'b0, 8'd2);
        repeat (4) step();
        strobe(2, 25'h55);
        chk("d_in_settle", cic_rst_n, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("d_busy", busy, 0);
        chk("d_cic_rst_n", cic_rst_n, 0);
        chk("d_done", done, 0);
        chk("d_no_sample", sample_valid, 0);
        step();
        chk("d_done_later", done, 0);

        // start during RUN is ignored; start with stop in IDLE is ignored
        do_start(1'b1, 8'd0);
        repeat (4) step();
        for (int i = 0; i < 3; i++) strobe(2, 25'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e_run_start_busy", busy, 1);
        chk("e_run_start_cic_rst_n", cic_rst_n, 1);
        step();
        chk("e_run_still", cic_rst_n, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("e_stopped", busy, 0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("e_start_stop_busy", busy, 0);
        chk("e_start_stop_cic_rst_n", cic_rst_n, 0);

        // num_samples=0 means 256 strobes in RUN
        do_start(1'b0, 8'd0);
        repeat (4) step();
        for (int i = 0; i < 3; i++) strobe(2, 25'h0);
        early_done = 1'b0;
        for (int i = 0; i < 255; i++) begin
            strobe(1, 25'h1000 + NB'(i));
            if (done || !busy) early_done = 1'b1;
        end
        chk("f_no_early_done", early_done, 0);
        strobe(1, 25'h10FF);
        chk("f_done_256", done, 1);
        chk("f_busy_256", busy, 0);
        chk("f_last_data", sample_data, 32'h10FF);
        chk("f_last_valid", sample_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_conv_ctrl.md
CIC_CONV_CTRL -- requirements
Module: cic_conv_ctrl

Interface
REQ-001 Parameter NUMBITS, default 25, SHALL set the sample width and match the CIC output width.
REQ-002 Parameter SETTLE_SAMPLES, default 3, SHALL set the number of decimated samples discarded after filter flush.
REQ-003 Parameter FLUSH_CYCLES, default 4, SHALL set the number of clk cycles the CIC is held in reset at conversion start.
REQ-004 Ports SHALL be as follows:
 - clk, input, 1: modulator clock; sole clock, rising edge.
 - reset_n, input, 1: asynchronous active-low reset.
 - start, input, 1: one-cycle pulse that begins a conversion.
 - stop, input, 1: one-cycle pulse that aborts or ends a conversion.
 - continuous, input, 1: 1 = free-running; 0 = single-shot; sampled on start.
 - num_samples, input, 8: single-shot sample count, sampled on start; 0 means 256.
 - cic_strobe, input, 1: one-cycle pulse when the CIC output updates.
 - cic_out, input, NUMBITS: CIC decimated output.
 - cic_rst_n, output, 1: registered soft reset to the CIC, active low.
 - sample_data, output, NUMBITS: buffered sample.
 - sample_valid, output, 1: sample_data is valid.
 - sample_ready, input, 1: consumer accepts sample_data.
 - busy, output, 1: high in any state other than IDLE.
 - done, output, 1: one-cycle pulse on single-shot completion.
 - overflow, output, 1: sticky flag set when a sample is dropped.

Function
REQ-005 The FSM SHALL have four states: IDLE, FLUSH, SETTLE and RUN.
REQ-006 In IDLE the block SHALL drive cic_rst_n=0; start SHALL move it to FLUSH and clear overflow.
REQ-007 FLUSH SHALL hold cic_rst_n=0 for exactly FLUSH_CYCLES cycles, then enter SETTLE with cic_rst_n=1 on the next cycle.
REQ-008 SETTLE SHALL count cic_strobe pulses, discard the first SETTLE_SAMPLES samples, and enter RUN on the last discarded strobe.
REQ-009 In RUN, each cic_strobe SHALL write cic_out into the buffer in the same cycle.
REQ-010 In single-shot mode, the Nth accepted-or-dropped strobe SHALL cause a transition to IDLE, with a done pulse in the following cycle.
REQ-011 In continuous mode, RUN SHALL persist until stop.
REQ-012 stop in FLUSH, SETTLE or RUN SHALL force IDLE on the next edge with no done pulse; buffered samples SHALL be retained.
REQ-013 start outside IDLE SHALL be ignored; start and stop in the same cycle in IDLE SHALL be ignored (stop wins).
REQ-014 A strobe arriving while the buffer is full and no read occurs that cycle SHALL drop the sample, set overflow, and still count toward num_samples.
REQ-015 Handshake: a sample SHALL transfer when sample_valid & sample_ready; sample_data SHALL hold stable while sample_valid & !sample_ready.
REQ-016 Simultaneous write and read on a full buffer SHALL accept the write.
REQ-017 Simultaneous write and read on an empty buffer SHALL present the new sample the next cycle (no bypass path).
REQ-018 Write-to-sample_valid latency SHALL be 1 cycle.
REQ-019 Sample counters SHALL be 9 bits wide so that 256 is representable without wrap.
REQ-020 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-021 On reset_n=0, state=IDLE, cic_rst_n=0, sample_valid=0, sample_data=0, busy=0, done=0, overflow=0, and all counters and buffer pointers SHALL be 0, asynchronously.
REQ-022 Reset mid-conversion SHALL discard all buffered samples.

Configuration
REQ-023 With CIC_CTRL_FIFO_EN defined, the buffer SHALL be a 4-entry FIFO; without it, the buffer SHALL be a single holding register (full when sample_valid=1), and all other behaviour SHALL be unchanged.

Verification
REQ-024 Scenario: start, continuous=0, num_samples=2, strobes every 256 clk, sample_ready=1 -> cic_rst_n low for 4 cycles, 3 strobes discarded, 2 samples output, done pulse, busy=0.
REQ-025 Scenario: continuous=1, sample_ready=0, 6 strobes in RUN -> FIFO build: 4 held, overflow=1; non-FIFO build: 1 held, overflow=1; then ready=1 -> held samples drain in order.
REQ-026 Scenario: stop during SETTLE after 1 strobe -> IDLE next cycle, cic_rst_n=0, no done, no sample output.
REQ-027 Scenario: num_samples=0 in single-shot -> exactly 256 strobes counted in RUN before done.
REQ-028 Scenario: reset_n pulsed low in RUN with 2 samples buffered -> sample_valid=0 immediately, state=IDLE, overflow=0.
REQ-029 Scenario: start asserted during RUN, and start with stop in IDLE -> no state change in either case.
